kmeans_cluster_stats: RTL and testbench

Downstream stage of the two-cluster 1-D K-means clusterer. Accepts one frame of N samples plus the per-sample cluster assignment bits, then produces per-cluster statistics over a valid/ready handshake: count, sum, floor mean, min and max. The stage walks the samples serially and computes both means with a shared-structure serial divider. Frames are processed one at a time.

---
 rtl/kmeans_pkg.sv | 62 ++++++
 rtl/kmeans_serial_div.sv | 73 +++++++
 rtl/kmeans_cluster_stats.sv | 160 ++++++++++++++++
 tb/tb_kmeans_cluster_stats.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_pkg.sv
// Shared constants, FSM state encoding and per-cluster statistics record
// for the two-cluster K-means statistics stage.
package kmeans_pkg;

    localparam int unsigned N_SAMPLES = 8;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned CNT_W     = $clog2(N_SAMPLES + 1);
    localparam int unsigned SUM_W     = DATA_W + $clog2(N_SAMPLES);
    localparam int unsigned IDX_W     = $clog2(N_SAMPLES);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DIV,
        DONE
    } state_t;

    typedef struct packed {
        logic [CNT_W-1:0]  cnt;
        logic [SUM_W-1:0]  sum;
        logic [DATA_W-1:0] mean;
        logic [DATA_W-1:0] min;
        logic [DATA_W-1:0] max;
        logic              empty;
    } cluster_stats_t;

    // Accumulator state at the start of a frame: min saturated high so the
    // first sample always replaces it.
    function automatic cluster_stats_t stats_clear();
        cluster_stats_t r;
        r     = '0;
        r.min = '1;
        return r;
    endfunction

    // Fold one sample into a cluster's running count/sum/extremes.
    function automatic cluster_stats_t stats_add(input cluster_stats_t s,
                                                 input logic [DATA_W-1:0] x);
        cluster_stats_t r;
        r     = s;
        r.cnt = s.cnt + 1'b1;
        r.sum = s.sum + SUM_W'(x);
        if (x < s.min) r.min = x;
        if (x > s.max) r.max = x;
        return r;
    endfunction

    // Final record: attach the mean and zero the extremes of an empty cluster.
    function automatic cluster_stats_t stats_final(input cluster_stats_t acc,
                                                   input logic [DATA_W-1:0] q);
        cluster_stats_t r;
        r       = acc;
        r.mean  = q;
        r.empty = (acc.cnt == '0);
        if (acc.cnt == '0) begin
            r.min = '0;
            r.max = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/kmeans_serial_div.sv
// Restoring serial divider with a fixed latency of DIVIDEND_W steps.
// The first step is taken on the start edge using the input operands, so the
// final quotient appears on `quotient` while `done` is high (combinational)
// and is valid to capture on that same edge. Divide-by-zero yields 0.
module kmeans_serial_div
    import kmeans_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = SUM_W,
    parameter int unsigned DIVISOR_W  = CNT_W,
    parameter int unsigned QUOT_W     = DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [QUOT_W-1:0]     quotient,
    output logic                  done
);

    localparam int unsigned STEP_W = $clog2(DIVIDEND_W);

    logic [DIVISOR_W-1:0]  rem;
    logic [DIVIDEND_W-1:0] shq;
    logic [DIVISOR_W-1:0]  dsr;
    logic [STEP_W-1:0]     step;
    logic                  busy;

    logic [DIVISOR_W-1:0]  cur_rem;
    logic [DIVIDEND_W-1:0] cur_q;
    logic [DIVISOR_W-1:0]  cur_dsr;
    logic [DIVISOR_W:0]    trial;
    logic                  take;
    logic [DIVISOR_W-1:0]  rem_nxt;
    logic [DIVIDEND_W-1:0] q_nxt;

    // One restoring step; operands come from the ports on the start cycle.
    always_comb begin
        cur_rem = start ? '0 : rem;
        cur_q   = start ? dividend : shq;
        cur_dsr = start ? divisor : dsr;
        trial   = {cur_rem, cur_q[DIVIDEND_W-1]};
        take    = (cur_dsr != '0) && (trial >= {1'b0, cur_dsr});
        rem_nxt = take ? DIVISOR_W'(trial - {1'b0, cur_dsr}) : trial[DIVISOR_W-1:0];
        q_nxt   = {cur_q[DIVIDEND_W-2:0], take};
    end

    assign quotient = q_nxt[QUOT_W-1:0];
    assign done     = busy && (step == STEP_W'(DIVIDEND_W - 1));

    // Shift register holds remaining dividend bits and the growing quotient.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem  <= '0;
            shq  <= '0;
            dsr  <= '0;
            step <= '0;
            busy <= 1'b0;
        end else if (start) begin
            rem  <= rem_nxt;
            shq  <= q_nxt;
            dsr  <= divisor;
            step <= STEP_W'(1);
            busy <= 1'b1;
        end else if (busy) begin
            rem  <= rem_nxt;
            shq  <= q_nxt;
            step <= step + 1'b1;
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/kmeans_cluster_stats.sv
// Per-cluster statistics (count, sum, floor mean, min, max) for one frame of
// samples with 1-bit cluster assignments. Samples are walked serially, then
// both means are computed by two parallel serial dividers.
module kmeans_cluster_stats
    import kmeans_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_SAMPLES*DATA_W-1:0]   in_data,
    input  logic [N_SAMPLES-1:0]          in_assign,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CNT_W-1:0]              cnt0,
    output logic [CNT_W-1:0]              cnt1,
    output logic [SUM_W-1:0]              sum0,
    output logic [SUM_W-1:0]              sum1,
    output logic [DATA_W-1:0]             mean0,
    output logic [DATA_W-1:0]             mean1,
    output logic [DATA_W-1:0]             min0,
    output logic [DATA_W-1:0]             max0,
    output logic [DATA_W-1:0]             min1,
    output logic [DATA_W-1:0]             max1,
    output logic                          empty0,
    output logic                          empty1
);

    state_t state, state_nxt;

    logic [N_SAMPLES*DATA_W-1:0] data_q;
    logic [N_SAMPLES-1:0]        asg_q;
    logic [IDX_W-1:0]            idx;
    logic [DATA_W-1:0]           sample;

    cluster_stats_t acc0, acc1;
    cluster_stats_t res0, res1;

    logic              div_start;
    logic [DATA_W-1:0] q0, q1;
    logic              done0, done1;

    logic accept, last_sample, div_finish, handshake;

    assign sample = data_q[DATA_W-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)      state_nxt = ACCUM;
            ACCUM:   if (last_sample) state_nxt = DIV;
            DIV:     if (div_finish)  state_nxt = DONE;
            DONE:    if (handshake)   state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Control strobes decoded from state and handshakes.
    always_comb begin
        accept      = (state == IDLE) && in_valid && in_ready;
        last_sample = (state == ACCUM) && (idx == IDX_W'(N_SAMPLES - 1));
        div_finish  = (state == DIV) && done0 && done1;
        handshake   = (state == DONE) && out_valid && out_ready;
    end

    // Frame capture and serial accumulation; samples are shifted out LSB first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q    <= '0;
            asg_q     <= '0;
            idx       <= '0;
            acc0      <= '0;
            acc1      <= '0;
            div_start <= 1'b0;
        end else begin
            div_start <= last_sample;
            if (accept) begin
                data_q <= in_data;
                asg_q  <= in_assign;
                idx    <= '0;
                acc0   <= stats_clear();
                acc1   <= stats_clear();
            end else if (state == ACCUM) begin
                data_q <= data_q >> DATA_W;
                asg_q  <= asg_q >> 1;
                idx    <= idx + 1'b1;
                if (asg_q[0]) acc1 <= stats_add(acc1, sample);
                else          acc0 <= stats_add(acc0, sample);
            end
        end
    end

    kmeans_serial_div #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (CNT_W),
        .QUOT_W     (DATA_W)
    ) u_div0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (acc0.sum),
        .divisor  (acc0.cnt),
        .quotient (q0),
        .done     (done0)
    );

    kmeans_serial_div #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (CNT_W),
        .QUOT_W     (DATA_W)
    ) u_div1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (acc1.sum),
        .divisor  (acc1.cnt),
        .quotient (q1),
        .done     (done1)
    );

    // Registered outputs; results persist after the handshake until the next frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res0      <= '0;
            res1      <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            in_ready <= (state_nxt == IDLE);
            if (div_finish) begin
                res0      <= stats_final(acc0, q0);
                res1      <= stats_final(acc1, q1);
                out_valid <= 1'b1;
            end else if (handshake) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign cnt0   = res0.cnt;
    assign sum0   = res0.sum;
    assign mean0  = res0.mean;
    assign min0   = res0.min;
    assign max0   = res0.max;
    assign empty0 = res0.empty;
    assign cnt1   = res1.cnt;
    assign sum1   = res1.sum;
    assign mean1  = res1.mean;
    assign min1   = res1.min;
    assign max1   = res1.max;
    assign empty1 = res1.empty;

endmodule

// File: tb/tb_kmeans_cluster_stats.sv
// Scoreboard bench for kmeans_cluster_stats: stimulus pushes expected records,
// a negedge monitor pops and compares on each output handshake.
module tb_kmeans_cluster_stats;
    import kmeans_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        in_valid;
    logic                        in_ready;
    logic [N_SAMPLES*DATA_W-1:0] in_data;
    logic [N_SAMPLES-1:0]        in_assign;
    logic                        out_valid;
    logic                        out_ready;
    logic [CNT_W-1:0]            cnt0, cnt1;
    logic [SUM_W-1:0]            sum0, sum1;
    logic [DATA_W-1:0]           mean0, mean1, min0, max0, min1, max1;
    logic                        empty0, empty1;

    kmeans_cluster_stats dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_assign (in_assign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .sum0      (sum0),
        .sum1      (sum1),
        .mean0     (mean0),
        .mean1     (mean1),
        .min0      (min0),
        .max0      (max0),
        .min1      (min1),
        .max1      (max1),
        .empty0    (empty0),
        .empty1    (empty1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned c0, s0, m0, n0, x0, e0;
        int unsigned c1, s1, m1, n1, x1, e1;
    } exp_t;

    exp_t exp_q[$];
    int   acc_cyc_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   prev_ov = 1'b0;
    exp_t mon_e;

    task automatic chk(input string nm, input int unsigned act, input int unsigned want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    task automatic fail(input string msg);
        total++;
        bad++;
        $display("FAIL %s", msg);
    endtask

    function automatic exp_t mk(input int unsigned c0, s0, m0, n0, x0, e0,
                                input int unsigned c1, s1, m1, n1, x1, e1);
        exp_t e;
        e.c0 = c0; e.s0 = s0; e.m0 = m0; e.n0 = n0; e.x0 = x0; e.e0 = e0;
        e.c1 = c1; e.s1 = s1; e.m1 = m1; e.n1 = n1; e.x1 = x1; e.e1 = e1;
        return e;
    endfunction

    function automatic logic [63:0] pk(input int unsigned b0, b1, b2, b3,
                                       input int unsigned b4, b5, b6, b7);
        return {8'(b7), 8'(b6), 8'(b5), 8'(b4), 8'(b3), 8'(b2), 8'(b1), 8'(b0)};
    endfunction

    // Reference model used for the random frames.
    function automatic exp_t model(input logic [63:0] d, input logic [7:0] a);
        int unsigned c[2];
        int unsigned s[2];
        int unsigned mn[2];
        int unsigned mx[2];
        int unsigned x;
        int          k;
        exp_t        e;
        for (int j = 0; j < 2; j++) begin
            c[j] = 0; s[j] = 0; mn[j] = 255; mx[j] = 0;
        end
        for (int i = 0; i < 8; i++) begin
            x = 32'(d[i*8 +: 8]);
            k = a[i] ? 1 : 0;
            c[k]++;
            s[k] += x;
            if (x < mn[k]) mn[k] = x;
            if (x > mx[k]) mx[k] = x;
        end
        e.c0 = c[0]; e.s0 = s[0];
        e.m0 = (c[0] != 0) ? s[0] / c[0] : 0;
        e.n0 = (c[0] != 0) ? mn[0] : 0;
        e.x0 = (c[0] != 0) ? mx[0] : 0;
        e.e0 = (c[0] == 0) ? 1 : 0;
        e.c1 = c[1]; e.s1 = s[1];
        e.m1 = (c[1] != 0) ? s[1] / c[1] : 0;
        e.n1 = (c[1] != 0) ? mn[1] : 0;
        e.x1 = (c[1] != 0) ? mx[1] : 0;
        e.e1 = (c[1] == 0) ? 1 : 0;
        return e;
    endfunction

    // Accept recorder: cycle index of each accepted frame.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) acc_cyc_q.delete();
        else if (in_valid && in_ready) acc_cyc_q.push_back(cyc);
    end

    // Monitor: latency on out_valid rise, field compare on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !prev_ov) begin
                if (acc_cyc_q.size() == 0) fail("out_valid rose with no accepted frame");
                else chk("latency", 32'(cyc - acc_cyc_q.pop_front()), 19);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail("output handshake with no expected frame");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("cnt0",   32'(cnt0),   mon_e.c0);
                    chk("sum0",   32'(sum0),   mon_e.s0);
                    chk("mean0",  32'(mean0),  mon_e.m0);
                    chk("min0",   32'(min0),   mon_e.n0);
                    chk("max0",   32'(max0),   mon_e.x0);
                    chk("empty0", 32'(empty0), mon_e.e0);
                    chk("cnt1",   32'(cnt1),   mon_e.c1);
                    chk("sum1",   32'(sum1),   mon_e.s1);
                    chk("mean1",  32'(mean1),  mon_e.m1);
                    chk("min1",   32'(min1),   mon_e.n1);
                    chk("max1",   32'(max1),   mon_e.x1);
                    chk("empty1", 32'(empty1), mon_e.e1);
                end
            end
        end
        prev_ov = out_valid;
    end

    task automatic send(input logic [63:0] d, input logic [7:0] a, input exp_t e,
                        input bit push, input bit hold, output int waited);
        bit got;
        got       = 1'b0;
        waited    = 0;
        in_data   = d;
        in_assign = a;
        in_valid  = 1'b1;
        while (!got && waited < 60) begin
            @(posedge clk);
            waited++;
            if (rst_n && in_ready) got = 1'b1;
        end
        if (!got) fail("frame not accepted within 60 cycles");
        else if (push) exp_q.push_back(e);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail("expected output not seen within 100 cycles");
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_cnt0"},  32'(cnt0),  0);
        chk({tag, "_cnt1"},  32'(cnt1),  0);
        chk({tag, "_sum0"},  32'(sum0),  0);
        chk({tag, "_sum1"},  32'(sum1),  0);
        chk({tag, "_mean0"}, 32'(mean0), 0);
        chk({tag, "_mean1"}, 32'(mean1), 0);
        chk({tag, "_min0"},  32'(min0),  0);
        chk({tag, "_max0"},  32'(max0),  0);
        chk({tag, "_min1"},  32'(min1),  0);
        chk({tag, "_max1"},  32'(max1),  0);
        chk({tag, "_empty0"}, 32'(empty0), 0);
        chk({tag, "_empty1"}, 32'(empty1), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        int          seen;
        logic [63:0] rd;
        logic [7:0]  ra;
        exp_t        dummy;

        dummy     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_assign = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_release", 32'(in_ready), 1);

        // Two balanced clusters.
        send(pk(10, 20, 30, 40, 200, 210, 220, 230), 8'hF0,
             mk(4, 100, 25, 10, 40, 0, 4, 860, 215, 200, 230, 0), 1'b1, 1'b0, w);
        drain();

        // Everything in cluster 0 at full scale, cluster 1 empty.
        send(pk(255, 255, 255, 255, 255, 255, 255, 255), 8'h00,
             mk(8, 2040, 255, 255, 255, 0, 0, 0, 0, 0, 0, 1), 1'b1, 1'b0, w);
        drain();

        // Truncating means: 3/2 and 19/6.
        send(pk(1, 2, 3, 3, 3, 3, 3, 4), 8'hFC,
             mk(2, 3, 1, 1, 2, 0, 6, 19, 3, 3, 4, 0), 1'b1, 1'b0, w);
        drain();

        // Back-pressure in DONE while a second frame is offered.
        out_ready = 1'b0;
        send(pk(10, 20, 30, 40, 200, 210, 220, 230), 8'hF0,
             mk(4, 100, 25, 10, 40, 0, 4, 860, 215, 200, 230, 0), 1'b1, 1'b0, w);
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        chk("stall_out_valid_seen", 32'(seen), 1);
        for (int i = 0; i < 10; i++) begin
            in_valid  = (i % 2 == 0);
            in_data   = pk(1, 2, 3, 4, 5, 6, 7, 8);
            in_assign = 8'h55;
            @(posedge clk);
            #1;
            chk("stall_in_ready",  32'(in_ready),  0);
            chk("stall_out_valid", 32'(out_valid), 1);
            chk("stall_mean0",     32'(mean0),     25);
            chk("stall_sum1",      32'(sum1),      860);
            chk("stall_min1",      32'(min1),      200);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_handshake",  32'(in_ready),  1);
        chk("out_valid_after_handshake", 32'(out_valid), 0);
        chk("mean1_kept_after_handshake", 32'(mean1), 215);
        chk("max0_kept_after_handshake",  32'(max0),  40);
        @(posedge clk);
        #1;

        // Reset while dividing: frame is dropped, outputs cleared.
        send(pk(10, 20, 30, 40, 200, 210, 220, 230), 8'h0F, dummy, 1'b0, 1'b0, w);
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_zero("midreset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_midreset", 32'(in_ready), 1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        chk("aborted_frame_no_out_valid", 32'(seen), 0);
        send(pk(5, 6, 7, 8, 9, 10, 11, 12), 8'hAA,
             mk(4, 32, 8, 5, 11, 0, 4, 36, 9, 6, 12, 0), 1'b1, 1'b0, w);
        drain();

        // Back-to-back random frames, one accept every 21 cycles.
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            rd = {$urandom, $urandom};
            ra = 8'($urandom);
            send(rd, ra, model(rd, ra), 1'b1, 1'b1, w);
            if (k > 0) chk("accept_spacing", 32'(w), 21);
        end
        in_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
